// File: rtl/regfile_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard_pkg
// Shared sizing constants for the integer register file and its scoreboard.
// The register file, the busy tracker and the pipeline stages that talk to
// them all import this package, so they agree on widths and on the x0 index.
// -----------------------------------------------------------------------------
package regfile_scoreboard_pkg;

    localparam int RF_XLEN = 64;               // register / data width
    localparam int RF_NREG = 32;               // architectural register count
    localparam int RF_AW   = $clog2(RF_NREG);  // register address width
    localparam int RF_X0   = 0;                // hard-wired zero register index

endpackage

// File: rtl/regfile_scoreboard_busy_tracker.sv
// -----------------------------------------------------------------------------
// sb_busy_tracker
// Holds one pending-write flag per register and produces the operand-ready
// and issue-ready handshakes. A writeback landing in the current cycle counts
// as "ready" because the top level forwards its data through the bypass.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   rs1_addr, rs2_addr    source register addresses
//   issue_valid, issue_rd instruction claiming issue_rd as its destination
//   wb_valid, wb_rd       writeback strobe and destination
//   rs1_ready, rs2_ready  operand usable this cycle
//   issue_ready           issue_rd may be claimed this cycle
//   busy_vec              registered busy flags (no bypass term)
// -----------------------------------------------------------------------------
module sb_busy_tracker
    import regfile_scoreboard_pkg::*;
#(
    parameter int NREG = RF_NREG,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    output logic            rs1_ready,
    output logic            rs2_ready,
    output logic            issue_ready,
    output logic [NREG-1:0] busy_vec
);

    logic [NREG-1:0] r_busy;
    logic            w_accept;

    // Same rule for operands and for the WAW check on the destination.
    function automatic logic f_ready(input logic [AW-1:0] a);
        return (a == AW'(RF_X0)) | ~r_busy[a] | (wb_valid & (wb_rd == a));
    endfunction

    assign rs1_ready   = f_ready(rs1_addr);
    assign rs2_ready   = f_ready(rs2_addr);
    assign issue_ready = f_ready(issue_rd);
    assign w_accept    = issue_valid & issue_ready;
    assign busy_vec    = r_busy;

    // Issue is tested before writeback so that a same-edge issue and
    // writeback to one register leaves it busy: the new writer wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy[RF_X0] <= 1'b0;
            for (int i = 1; i < NREG; i++) begin
                if (w_accept && (issue_rd == AW'(i)))
                    r_busy[i] <= 1'b1;
                else if (wb_valid && (wb_rd == AW'(i)))
                    r_busy[i] <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// NREG x XLEN integer register file with a per-register pending-write
// scoreboard. Reads are combinational with a same-cycle writeback bypass;
// x0 always reads 0 and is never written or marked busy.
//
// Ports
//   clk, rst_n                   clock, async active-low reset
//   rs1_addr/rs2_addr            source addresses from decode
//   rs1_data/rs2_data            operand values to the ALU
//   rs1_ready/rs2_ready          operand valid this cycle
//   issue_valid/issue_rd         destination claim from the issuing instr
//   issue_ready                  destination may be claimed (no WAW pending)
//   wb_valid/wb_rd/wb_data       ALU result writeback
//   busy_vec                     registered pending-write flags
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int XLEN = RF_XLEN,
    parameter int NREG = RF_NREG,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_ready,
    output logic            rs2_ready,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [NREG-1:0] busy_vec
);

    logic [NREG-1:0][XLEN-1:0] r_regs;
    logic                      w_wr_en;

    // Writes to x0 are dropped, so r_regs[0] stays at its reset value of 0.
    assign w_wr_en = wb_valid & (wb_rd != AW'(RF_X0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_regs <= '0;
        else if (w_wr_en)
            r_regs[wb_rd] <= wb_data;
    end

    // Bypass a writeback landing this cycle; never bypass into x0.
    function automatic logic [XLEN-1:0] f_read(input logic [AW-1:0] a);
        if (a == AW'(RF_X0))
            return '0;
        else if (wb_valid && (wb_rd == a))
            return wb_data;
        else
            return r_regs[a];
    endfunction

    assign rs1_data = f_read(rs1_addr);
    assign rs2_data = f_read(rs2_addr);

    sb_busy_tracker #(
        .NREG (NREG),
        .AW   (AW)
    ) u_busy (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .rs1_ready   (rs1_ready),
        .rs2_ready   (rs2_ready),
        .issue_ready (issue_ready),
        .busy_vec    (busy_vec)
    );

endmodule
